// File: rtl/bus_cycle_pkg.sv
// rtl/bus_cycle_pkg.sv - state and status encodings for the 8085-style bus cycle generator
package bus_cycle_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5
    } state_t;

    localparam logic [1:0] ST_HALT  = 2'b00;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_READ  = 2'b10;
    localparam logic [1:0] ST_FETCH = 2'b11;

    // A fetch flag on a write is meaningless, so write wins.
    function automatic logic [1:0] cycle_status(input logic wr, input logic fetch);
        if (wr)
            return ST_WRITE;
        else if (fetch)
            return ST_FETCH;
        else
            return ST_READ;
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - initiator-side multiplexed AD-bus cycle generator (T1/T2/TW/T3/T4)
module bus_cycle_ctrl
    import bus_cycle_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter bit FETCH_T4 = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_wr,
    input  logic        req_io,
    input  logic        req_fetch,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        ready,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic [7:0]  haddress,
    output logic        ALE,
    output logic        RDn,
    output logic        WRn,
    output logic        IOMn,
    output logic        S0,
    output logic        S1,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        timeout
);

    localparam logic [7:0] LP_MAX_WAIT = MAX_WAIT[7:0];

    state_t      r_state;
    logic        r_wr;
    logic        r_io;
    logic        r_fetch;
    logic [7:0]  r_wdata;
    logic [7:0]  r_wait_cnt;

    logic [7:0]  r_ad_out;
    logic        r_ad_oe;
    logic [7:0]  r_haddr;
    logic        r_ale;
    logic        r_rdn;
    logic        r_wrn;
    logic        r_iomn;
    logic [1:0]  r_status;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_rdata;
    logic        r_timeout;

    state_t      w_next;
    logic [7:0]  w_ad_out;
    logic        w_ad_oe;
    logic [7:0]  w_haddr;
    logic        w_ale;
    logic        w_rdn;
    logic        w_wrn;
    logic        w_iomn;
    logic [1:0]  w_status;
    logic        w_busy;
    logic        w_wait_full;

    assign w_wait_full = (r_wait_cnt == LP_MAX_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Outputs are registered from the next state, so each pin settles
    // at the start of the bus state it belongs to.
    always_comb begin
        w_next   = r_state;
        w_ad_out = r_ad_out;
        w_ad_oe  = 1'b0;
        w_haddr  = r_haddr;
        w_ale    = 1'b0;
        w_rdn    = 1'b1;
        w_wrn    = 1'b1;
        w_iomn   = r_iomn;
        w_status = r_status;
        w_busy   = 1'b0;

        case (r_state)
            IDLE:    w_next = req ? T1 : IDLE;
            T1:      w_next = T2;
            T2:      w_next = ready ? T3 : TW;
            TW:      w_next = (ready || w_wait_full) ? T3 : TW;
            T3:      w_next = (r_fetch && FETCH_T4) ? T4 : IDLE;
            T4:      w_next = IDLE;
            default: w_next = IDLE;
        endcase

        case (w_next)
            IDLE: begin
                w_haddr  = 8'h00;
                w_status = ST_HALT;
            end
            T1: begin
                w_ale    = 1'b1;
                w_ad_out = req_addr[7:0];
                w_ad_oe  = 1'b1;
                w_haddr  = req_addr[15:8];
                w_iomn   = req_io;
                w_status = cycle_status(req_wr, req_fetch);
                w_busy   = 1'b1;
            end
            T2, TW, T3: begin
                w_busy = 1'b1;
                if (r_wr) begin
                    w_wrn    = 1'b0;
                    w_ad_out = r_wdata;
                    w_ad_oe  = 1'b1;
                end else begin
                    w_rdn    = 1'b0;
                end
            end
            T4:      w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr       <= 1'b0;
            r_io       <= 1'b0;
            r_fetch    <= 1'b0;
            r_wdata    <= 8'h00;
            r_wait_cnt <= 8'h00;
            r_done     <= 1'b0;
            r_rdata    <= 8'h00;
            r_timeout  <= 1'b0;
        end else begin
            r_done <= (r_state == T3);
            if (r_state == IDLE && req) begin
                r_wr      <= req_wr;
                r_io      <= req_io;
                r_fetch   <= req_fetch & ~req_wr;
                r_wdata   <= req_wdata;
                r_timeout <= 1'b0;
            end
            if (r_state == T2)
                r_wait_cnt <= 8'd1;
            else if (r_state == TW && !ready && !w_wait_full)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_state == TW && !ready && w_wait_full)
                r_timeout <= 1'b1;
            if (r_state == T3 && !r_wr)
                r_rdata <= ad_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ad_out <= 8'h00;
            r_ad_oe  <= 1'b0;
            r_haddr  <= 8'h00;
            r_ale    <= 1'b0;
            r_rdn    <= 1'b1;
            r_wrn    <= 1'b1;
            r_iomn   <= 1'b0;
            r_status <= ST_HALT;
            r_busy   <= 1'b0;
        end else begin
            r_ad_out <= w_ad_out;
            r_ad_oe  <= w_ad_oe;
            r_haddr  <= w_haddr;
            r_ale    <= w_ale;
            r_rdn    <= w_rdn;
            r_wrn    <= w_wrn;
            r_iomn   <= w_iomn;
            r_status <= w_status;
            r_busy   <= w_busy;
        end
    end

    assign ad_out   = r_ad_out;
    assign ad_oe    = r_ad_oe;
    assign haddress = r_haddr;
    assign ALE      = r_ale;
    assign RDn      = r_rdn;
    assign WRn      = r_wrn;
    assign IOMn     = r_iomn;
    assign S1       = r_status[1];
    assign S0       = r_status[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign timeout  = r_timeout;

endmodule
